// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types, constants and sizing helpers for the
//                sequential binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Converter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int c_BIN_WIDTH_DFLT = 32;
  localparam int c_DIGITS_DFLT    = 8;

  // Largest value representable in `digits` decimal digits (10^digits - 1)
  function automatic logic [63:0] pow10_minus1(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  // Shift register holds the BCD field above the binary field
  function automatic int sr_width(input int bin_width, input int digits);
    return bin_width + 4 * digits;
  endfunction

  // Iteration counter must hold the value bin_width itself
  function automatic int cnt_width(input int bin_width);
    return $clog2(bin_width + 1);
  endfunction

  localparam int c_SR_WIDTH  = sr_width(c_BIN_WIDTH_DFLT, c_DIGITS_DFLT);
  localparam int c_CNT_WIDTH = cnt_width(c_BIN_WIDTH_DFLT);

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble nibble corrector: adds 3 to nibbles >= 5 so
//                the following left shift carries correctly into the next
//                decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  // Correct one BCD digit ahead of the shift
  always_comb begin
    o_nibble = i_nibble;
    if (i_nibble >= 4'd5) begin
      o_nibble = i_nibble + 4'd3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential double-dabble converter, one bit per cycle, with
//                valid/ready input, one-cycle done pulse and a held result
//                (saturates to all 9s with an overflow flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = c_BIN_WIDTH_DFLT,  // at most 64
  parameter int DIGITS    = c_DIGITS_DFLT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BIN_WIDTH-1:0]  in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  overflow
);

  localparam int                 c_SR_W      = sr_width(BIN_WIDTH, DIGITS);
  localparam int                 c_CNT_W     = cnt_width(BIN_WIDTH);
  localparam int                 c_BCD_W     = 4 * DIGITS;
  localparam logic [63:0]        c_MAX_VALUE = pow10_minus1(DIGITS);
  localparam logic [c_CNT_W-1:0] c_ITERS     = c_CNT_W'(BIN_WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [c_SR_W-1:0]   r_sr;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_ovf_pending;
  logic [c_BCD_W-1:0]  r_bcd_out;
  logic                r_overflow;
  logic [c_BCD_W-1:0]  w_bcd_adj;
  logic [c_SR_W-1:0]   w_sr_adj;
  logic [c_SR_W-1:0]   w_sr_next;
  logic                w_ovf_in;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .i_nibble (r_sr[BIN_WIDTH + 4*gi +: 4]),
        .o_nibble (w_bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Correct all digits, then shift; bits leaving the top are discarded
  always_comb begin
    w_sr_adj  = {w_bcd_adj, r_sr[BIN_WIDTH-1:0]};
    w_sr_next = w_sr_adj << 1;
    w_ovf_in  = 64'(in_value) > c_MAX_VALUE;
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode; both outputs are forced low in reset
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = reset;
        if (in_valid) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == c_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid    = reset;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: load on accept, shift while converting, capture on final shift
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sr          <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_bcd_out     <= '0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sr          <= {{c_BCD_W{1'b0}}, in_value};
            r_cnt         <= c_ITERS;
            r_ovf_pending <= w_ovf_in;
          end
        end
        SHIFT: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt - c_LAST;
          if (r_cnt == c_LAST) begin
            r_bcd_out  <= r_ovf_pending ? {DIGITS{4'h9}}
                                        : w_sr_next[c_SR_W-1 -: c_BCD_W];
            r_overflow <= r_ovf_pending;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd_out  = r_bcd_out;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter that turns a binary count into packed BCD digits.
- Sits directly upstream of the seven-segment display driver: the 1 Hz counter value enters here, and the packed BCD output feeds the display's eight digit inputs (digit1 = bcd_out[3:0] … digit8 = bcd_out[31:28]).
- Uses a valid/ready input handshake and a one-cycle done pulse.
- The output holds the last result so the display never shows partial values.

Parameters:
- BIN_WIDTH, 32: width of the binary input; equals the number of shift iterations.
- DIGITS, 8: number of BCD digits produced; bcd_out width is 4*DIGITS.

Ports:
- clock  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on the rising clock edge).
- in_value  in  BIN_WIDTH  binary value to convert.
- in_valid  in  1  in_value is valid this cycle.
- in_ready  out  1  converter can accept a value this cycle.
- bcd_out  out  4*DIGITS  packed BCD result; least significant digit in [3:0].
- out_valid  out  1  one-cycle pulse: bcd_out was updated this cycle.
- overflow  out  1  last accepted value exceeded 10^DIGITS-1; held with bcd_out.

Behaviour:
- Reset (reset==0 at an edge):
  - state <= IDLE; bcd_out <= 0; out_valid <= 0; overflow <= 0; internal shift/iteration registers cleared.
  - in_ready is 0 while reset is asserted.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid is high, the value is accepted at that edge. Shift register <= {DIGITS*4 zeros, in_value}, iteration counter <= BIN_WIDTH, ovf_pending <= (in_value > MAX_VALUE). Go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - in_ready=0.
  - Each cycle: every BCD nibble >= 5 gets +3 (combinational). The whole shift register then shifts left 1, and the counter decrements.
  - The cycle that performs the final shift (counter==1) transitions to DONE. At that edge: bcd_out <= BCD field (or all-9s if ovf_pending), and overflow <= ovf_pending.
  - BCD bits shifted out above DIGITS*4 are discarded; they only occur when overflow is set.
- DONE:
  - out_valid=1 for exactly this cycle; in_ready=0. Next state IDLE.
- Latency: acceptance edge = cycle 0. out_valid is high in cycle BIN_WIDTH+1 (33 with defaults). in_ready returns high in cycle BIN_WIDTH+2.
- Throughput: one conversion per BIN_WIDTH+2 cycles.
- Boundary conditions:
  - in_valid while in_ready=0: ignored, no queuing; the value is lost.
  - in_valid held continuously: a new conversion starts on every return to IDLE.
  - in_value = 0: bcd_out = 0, overflow = 0.
  - in_value = MAX_VALUE (99_999_999): all digits 9, overflow = 0.
  - in_value > MAX_VALUE: bcd_out = all 9s, overflow = 1; same latency.
  - Reset mid-SHIFT or mid-DONE: conversion aborted, no out_valid pulse, bcd_out = 0.
- bcd_out and overflow change only at the edge entering DONE or on reset; they are stable otherwise.
- No combinational path from in_value to any output.

Decomposition:
- Package bcd_pkg:
  - Enum type for FSM states (IDLE, SHIFT, DONE).
  - Constant function pow10_minus1(DIGITS) producing MAX_VALUE.
  - Localparam for the shift-register width (BIN_WIDTH + 4*DIGITS).
  - Counter width from $clog2(BIN_WIDTH+1).
- Sub-module: bcd_add3, a purely combinational 4-bit nibble corrector (nibble >= 5 ? nibble+3 : nibble). Instantiated DIGITS times via generate.

Test Plan:
1. Reset held low 3 cycles, then released; in_value=12_345_678, in_valid pulsed 1 cycle -> out_valid in cycle 33; bcd_out=32'h12345678; overflow=0; in_ready low cycles 1-33, high at 34.
2. in_value=0, then in_value=99_999_999 -> bcd_out 32'h00000000, then 32'h99999999; overflow=0 both times.
3. in_value=100_000_000, then 32'hFFFF_FFFF -> bcd_out=32'h99999999 and overflow=1 for both. Next conversion of 42 -> bcd_out=32'h00000042, overflow=0.
4. Accept 1234; at cycle 10 present in_valid with 5678 -> ignored; result 32'h00001234; exactly one out_valid pulse.
5. Accept 87_654_321; drive reset low at cycle 15 for 1 cycle -> no out_valid, bcd_out=0, in_ready=1 the cycle after release. New value 7 -> 32'h00000007.
6. in_valid held high, values incrementing each accepted conversion (counter_1s style) -> out_valid every 34 cycles; each bcd_out matches the decimal of the accepted value.
